// File: rtl/float_add_pipelined.sv
// -----------------------------------------------------------------------------
// float_add_pipelined
//   Fully pipelined IEEE-754 binary32 adder/subtractor (a + b; negate b for
//   subtraction). Accepts one operand pair per cycle; the rounded sum appears
//   exactly four clocks after the operands are sampled. No backpressure.
//   Subnormal inputs are flushed to zero, underflowing results flush to a
//   signed zero, rounding is nearest-even.
//
// Ports
//   clk              clock, all logic on the rising edge
//   rst_n            synchronous active-low reset (clears the valid chain only)
//   float_in_a       operand A, binary32
//   float_in_b       operand B, binary32
//   float_in_valid   operands valid this cycle
//   float_out        sum, binary32
//   float_ovf        overflow / Inf / NaN flag, qualified by float_out_valid
//   float_out_valid  float_out and float_ovf valid this cycle
// -----------------------------------------------------------------------------
module float_add_pipelined #(
    // Register-update delay used by the delayed-simulation variant of this
    // block; updates here are zero-delay, so the value has no effect.
    parameter real simulation_delay = 1.0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] float_in_a,
    input  logic [31:0] float_in_b,
    input  logic        float_in_valid,
    output logic [31:0] float_out,
    output logic        float_ovf,
    output logic        float_out_valid
);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // Valid chain: [0] operand register, [1..3] stage 1..3, [4] output.
    logic [4:0] valid_pipe;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge clk) begin
        if (!rst_n) valid_pipe <= '0;
        else        valid_pipe <= {valid_pipe[3:0], float_in_valid};
    end
    assign float_out_valid = valid_pipe[4];

    // ---------------- operand register ----------------
    logic [31:0] a_q, b_q;

    // NOTE: datapath registers carry no reset; only the valid chain is
    // cleared, and stale data is never qualified by a valid bit.
    always_ff @(posedge clk) begin
        a_q <= float_in_a;
        b_q <= float_in_b;
    end

    // ---------------- stage 1: unpack / compare ----------------
    logic [7:0]  exp_a, exp_b;
    logic [30:0] key_a, key_b;
    logic        nan_a, nan_b, inf_a, inf_b, a_ge_b;
    logic [31:0] special_val;

    always_comb begin
        exp_a  = a_q[30:23];
        exp_b  = b_q[30:23];
        // Zero exponent means zero: drop the fraction before comparing.
        key_a  = {exp_a, (exp_a == 8'd0) ? 23'd0 : a_q[22:0]};
        key_b  = {exp_b, (exp_b == 8'd0) ? 23'd0 : b_q[22:0]};
        a_ge_b = (key_a >= key_b);
        nan_a  = (exp_a == 8'hFF) && (a_q[22:0] != 23'd0);
        nan_b  = (exp_b == 8'hFF) && (b_q[22:0] != 23'd0);
        inf_a  = (exp_a == 8'hFF) && (a_q[22:0] == 23'd0);
        inf_b  = (exp_b == 8'hFF) && (b_q[22:0] == 23'd0);
        if (nan_a || nan_b || (inf_a && inf_b && (a_q[31] != b_q[31])))
            special_val = QNAN;
        else if (inf_a)
            special_val = {a_q[31], 8'hFF, 23'd0};
        else
            special_val = {b_q[31], 8'hFF, 23'd0};
    end

    logic        s1_sign, s1_sub, s1_special;
    logic [7:0]  s1_exp, s1_diff;
    logic [23:0] s1_sig_l, s1_sig_s;
    logic [31:0] s1_special_val;

    always_ff @(posedge clk) begin
        s1_sub         <= a_q[31] ^ b_q[31];
        s1_special     <= (exp_a == 8'hFF) || (exp_b == 8'hFF);
        s1_special_val <= special_val;
        if (a_ge_b) begin
            s1_sign  <= a_q[31];
            s1_exp   <= key_a[30:23];
            s1_diff  <= key_a[30:23] - key_b[30:23];
            s1_sig_l <= {key_a[30:23] != 8'd0, key_a[22:0]};
            s1_sig_s <= {key_b[30:23] != 8'd0, key_b[22:0]};
        end else begin
            s1_sign  <= b_q[31];
            s1_exp   <= key_b[30:23];
            s1_diff  <= key_b[30:23] - key_a[30:23];
            s1_sig_l <= {key_b[30:23] != 8'd0, key_b[22:0]};
            s1_sig_s <= {key_a[30:23] != 8'd0, key_a[22:0]};
        end
    end

    // ---------------- stage 2: align / add ----------------
    // Significands carry three extra LSBs: guard, round, sticky.
    logic [49:0] shift_ext;
    logic [26:0] aligned;
    logic [27:0] sum;

    always_comb begin
        shift_ext = {s1_sig_s, 26'd0} >> s1_diff;
        if (s1_diff >= 8'd26)
            aligned = {26'd0, |s1_sig_s};
        else
            aligned = {shift_ext[49:24], |shift_ext[23:0]};
        if (s1_sub) sum = {1'b0, s1_sig_l, 3'b000} - {1'b0, aligned};
        else        sum = {1'b0, s1_sig_l, 3'b000} + {1'b0, aligned};
    end

    logic        s2_sign, s2_special;
    logic [7:0]  s2_exp;
    logic [27:0] s2_sum;
    logic [31:0] s2_special_val;

    always_ff @(posedge clk) begin
        s2_sign        <= s1_sign;
        s2_exp         <= s1_exp;
        s2_sum         <= sum;
        s2_special     <= s1_special;
        s2_special_val <= s1_special_val;
    end

    // ---------------- stage 3: normalize ----------------
    logic [4:0]        lzc;
    logic [26:0]       norm;
    logic signed [9:0] norm_exp;
    logic              is_zero, zero_sign;

    // NOTE: every variable assigned here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        lzc = 5'd27;
        for (int i = 0; i < 27; i++)
            if (s2_sum[i]) lzc = 5'(26 - i);
        norm      = '0;
        norm_exp  = '0;
        is_zero   = 1'b0;
        zero_sign = 1'b0;
        if (s2_sum[27]) begin
            norm     = {s2_sum[27:2], s2_sum[1] | s2_sum[0]};
            norm_exp = $signed({2'b00, s2_exp}) + 10'sd1;
        end else begin
            norm     = s2_sum[26:0] << lzc;
            norm_exp = $signed({2'b00, s2_exp}) - $signed({5'd0, lzc});
            if (s2_sum[26:0] == 27'd0) begin
                is_zero = 1'b1;             // exact cancellation -> +0
            end else if (norm_exp <= 10'sd0) begin
                is_zero   = 1'b1;           // underflow -> signed zero
                zero_sign = s2_sign;
            end
        end
    end

    logic              s3_sign, s3_zero, s3_zero_sign, s3_special;
    logic [26:0]       s3_mant;
    logic signed [9:0] s3_exp;
    logic [31:0]       s3_special_val;

    always_ff @(posedge clk) begin
        s3_sign        <= s2_sign;
        s3_mant        <= norm;
        s3_exp         <= norm_exp;
        s3_zero        <= is_zero;
        s3_zero_sign   <= zero_sign;
        s3_special     <= s2_special;
        s3_special_val <= s2_special_val;
    end

    // ---------------- stage 4: round / pack ----------------
    logic              round_up;
    logic [24:0]       rounded;
    logic signed [9:0] final_exp;
    logic [22:0]       frac;
    logic [31:0]       result;
    logic              ovf;

    always_comb begin
        // Nearest-even: round up on G and (R or S or LSB).
        round_up  = s3_mant[2] & (s3_mant[1] | s3_mant[0] | s3_mant[3]);
        rounded   = {1'b0, s3_mant[26:3]} + 25'(round_up);
        final_exp = s3_exp;
        frac      = rounded[22:0];
        if (rounded[24]) begin
            final_exp = s3_exp + 10'sd1;
            frac      = rounded[23:1];
        end
        result = {s3_sign, final_exp[7:0], frac};
        ovf    = 1'b0;
        if (s3_special) begin
            result = s3_special_val;
            ovf    = 1'b1;
        end else if (s3_zero) begin
            result = {s3_zero_sign, 31'd0};
        end else if (final_exp >= 10'sd255) begin
            result = {s3_sign, 8'hFF, 23'd0};
            ovf    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        float_out <= result;
        float_ovf <= ovf;
    end

endmodule

// File: tb/tb_float_add_pipelined.sv
// -----------------------------------------------------------------------------
// tb_float_add_pipelined
//   Self-checking bench for float_add_pipelined. Expected sums come from a
//   constant vector table; each issued vector pushes its expected result and
//   due cycle onto a scoreboard queue, and a monitor pops and compares on
//   every float_out_valid.
// -----------------------------------------------------------------------------
module tb_float_add_pipelined;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] float_in_a, float_in_b;
    logic        float_in_valid;
    logic [31:0] float_out;
    logic        float_ovf;
    logic        float_out_valid;

    float_add_pipelined #(.simulation_delay(1.0)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .float_in_a      (float_in_a),
        .float_in_b      (float_in_b),
        .float_in_valid  (float_in_valid),
        .float_out       (float_out),
        .float_ovf       (float_ovf),
        .float_out_valid (float_out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sum;
        logic        ovf;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] sum;
        logic        ovf;
        int          due;
    } exp_t;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t sb[$];
    vec_t vecs[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Drive one operand pair; it is sampled at the next rising edge and its
    // result is due four edges after that, seen at the following falling edge.
    task automatic drive(input vec_t v);
        exp_t e;
        @(negedge clk);
        float_in_a     = v.a;
        float_in_b     = v.b;
        float_in_valid = 1'b1;
        e.name = v.name;
        e.sum  = v.sum;
        e.ovf  = v.ovf;
        e.due  = cyc + 5;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            float_in_a     = $urandom;
            float_in_b     = $urandom;
            float_in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    // Output monitor / scoreboard.
    always @(negedge clk) begin
        if (float_out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_sum"}, float_out, e.sum);
                check({e.name, "_ovf"}, {31'd0, float_ovf}, {31'd0, e.ovf});
                check({e.name, "_latency"}, 32'(cyc), 32'(e.due));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs.push_back('{"v1_roundup",   32'h3EEB851F, 32'h3FAB851F, 32'h3FE66667, 1'b0});
        vecs.push_back('{"v2_truncate",  32'h4077AE14, 32'h4268F5C3, 32'h427870A4, 1'b0});
        vecs.push_back('{"v3_cancel7",   32'h3FE3D70A, 32'hBFE28F5C, 32'h3C23D700, 1'b0});
        vecs.push_back('{"v4_b_larger",  32'h42078F5C, 32'hC2F1F5C3, 32'hC2AE2E15, 1'b0});
        vecs.push_back('{"v5_sticky",    32'h3D0B4396, 32'hC0DC0000, 32'hC0DAE979, 1'b0});
        vecs.push_back('{"v6_exact0",    32'h40FC7AE1, 32'hC0FC7AE1, 32'h00000000, 1'b0});
        vecs.push_back('{"ovf_max",      32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1'b1});
        vecs.push_back('{"ovf_round",    32'h7F7FFFFF, 32'h73000000, 32'h7F800000, 1'b1});
        vecs.push_back('{"max_plus0",    32'h7F7FFFFF, 32'h00000000, 32'h7F7FFFFF, 1'b0});
        vecs.push_back('{"tie_even_dn",  32'h3F800000, 32'h33800000, 32'h3F800000, 1'b0});
        vecs.push_back('{"tie_even_up",  32'h3F800001, 32'h33800000, 32'h3F800002, 1'b0});
        vecs.push_back('{"round_carry",  32'h3FFFFFFF, 32'h33800000, 32'h40000000, 1'b0});
        vecs.push_back('{"sticky_only",  32'h3F800000, 32'h30800000, 32'h3F800000, 1'b0});
        vecs.push_back('{"one_plus_one", 32'h3F800000, 32'h3F800000, 32'h40000000, 1'b0});
        vecs.push_back('{"subnorm_ftz",  32'h00000001, 32'h3F800000, 32'h3F800000, 1'b0});
        vecs.push_back('{"underflow_neg",32'h80800001, 32'h00800000, 32'h80000000, 1'b0});
        vecs.push_back('{"cancel_neg",   32'h80800000, 32'h00800000, 32'h00000000, 1'b0});
        vecs.push_back('{"inf_plus_1",   32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b1});
        vecs.push_back('{"ninf_plus_5",  32'h40A00000, 32'hFF800000, 32'hFF800000, 1'b1});
        vecs.push_back('{"inf_minus_inf",32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b1});
        vecs.push_back('{"nan_plus_1",   32'h7FC00000, 32'h3F800000, 32'h7FC00000, 1'b1});

        rst_n          = 1'b0;
        float_in_a     = '0;
        float_in_b     = '0;
        float_in_valid = 1'b0;

        // Reset held for ten cycles with valid stimulus: nothing may emerge.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            float_in_valid = 1'b1;
            check("reset_valid", {31'd0, float_out_valid}, 32'd0);
        end
        @(negedge clk);
        float_in_valid = 1'b0;
        rst_n          = 1'b1;
        idle(2);

        // Back-to-back: every vector in the table.
        foreach (vecs[i]) drive(vecs[i]);
        idle(1);
        drain();

        // Spec vectors 1-6 with random 0-2 idle cycles between them.
        for (int i = 0; i < 6; i++) begin
            drive(vecs[i]);
            idle($urandom_range(0, 2));
        end
        idle(1);
        drain();

        // Mid-stream reset: three results in flight are dropped.
        for (int i = 0; i < 3; i++) drive(vecs[i]);
        @(negedge clk);
        float_in_valid = 1'b0;
        rst_n          = 1'b0;
        sb.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst_valid", {31'd0, float_out_valid}, 32'd0);
        end
        rst_n = 1'b1;
        idle(10);  // monitor flags any valid emitted here

        // Pipeline resumes normally after reset.
        drive(vecs[3]);
        drive(vecs[4]);
        idle(1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
